// File: rtl/onehot_dec_pkg.sv
// Shared definitions for the one-hot decoder/scan sequencer: mode encoding,
// FSM state type and output-width derivation.
package onehot_dec_pkg;

  localparam logic [1:0] MODE_DECODE  = 2'b00;
  localparam logic [1:0] MODE_SCAN_UP = 2'b01;
  localparam logic [1:0] MODE_SCAN_DN = 2'b10;
  localparam logic [1:0] MODE_OFF     = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECODE,
    ST_SCAN_UP,
    ST_SCAN_DN
  } state_t;

  function automatic int unsigned out_width(input int unsigned sel_w);
    return 32'd1 << sel_w;
  endfunction

endpackage

// File: rtl/onehot_dec_dwell.sv
// Loadable down-counter timing how long the scan holds each position;
// tc is high while the count sits at zero.
module onehot_dec_dwell #(
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               load,
  input  logic [DWELL_W-1:0] load_val,
  output logic               tc
);

  logic [DWELL_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - DWELL_W'(1);
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/onehot_dec_seq.sv
// Registered binary-to-one-hot decoder with an up/down scan sequencer and
// programmable dwell per scan position.
module onehot_dec_seq
  import onehot_dec_pkg::*;
#(
  parameter  int unsigned SEL_W   = 2,
  parameter  int unsigned DWELL_W = 8,
  localparam int unsigned OUT_W   = out_width(SEL_W)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [1:0]         mode,
  input  logic [SEL_W-1:0]   sel,
  input  logic               sel_valid,
  input  logic [DWELL_W-1:0] dwell,
  output logic [OUT_W-1:0]   out,
  output logic               out_valid,
  output logic [SEL_W-1:0]   idx,
  output logic               wrap
);

  state_t             state;
  state_t             next_state;
  logic               entry;
  logic               scan_next;
  logic               cnt_clear;
  logic               cnt_load;
  logic               tc;
  logic [DWELL_W-1:0] reload;

  always_comb begin
    next_state = ST_IDLE;
    if (en) begin
      unique case (mode)
        MODE_DECODE:  next_state = ST_DECODE;
        MODE_SCAN_UP: next_state = ST_SCAN_UP;
        MODE_SCAN_DN: next_state = ST_SCAN_DN;
        default:      next_state = ST_IDLE;
      endcase
    end
  end

  // Any state change is a fresh entry, so scan direction flips restart position.
  assign entry     = (state != next_state);
  assign scan_next = (next_state == ST_SCAN_UP) || (next_state == ST_SCAN_DN);
  assign cnt_clear = !scan_next;
  assign cnt_load  = scan_next && (entry || tc);
  assign reload    = (dwell == '0) ? '0 : dwell - DWELL_W'(1);

  onehot_dec_dwell #(
    .DWELL_W (DWELL_W)
  ) u_dwell (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (cnt_clear),
    .load     (cnt_load),
    .load_val (reload),
    .tc       (tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      out       <= '0;
      out_valid <= 1'b0;
      idx       <= '0;
      wrap      <= 1'b0;
    end else begin
      state <= next_state;
      wrap  <= 1'b0;
      case (next_state)
        ST_IDLE: begin
          out       <= '0;
          out_valid <= 1'b0;
          idx       <= '0;
        end
        ST_DECODE: begin
          if (sel_valid) begin
            out       <= OUT_W'(1) << sel;
            idx       <= sel;
            out_valid <= 1'b1;
          end else if (entry) begin
            out       <= '0;
            out_valid <= 1'b0;
            idx       <= '0;
          end
        end
        ST_SCAN_UP: begin
          if (entry) begin
            out       <= OUT_W'(1);
            idx       <= '0;
            out_valid <= 1'b1;
          end else if (tc) begin
            out  <= {out[OUT_W-2:0], out[OUT_W-1]};
            idx  <= idx + SEL_W'(1);
            wrap <= (idx == '1);
          end
        end
        ST_SCAN_DN: begin
          if (entry) begin
            out       <= {1'b1, {(OUT_W-1){1'b0}}};
            idx       <= '1;
            out_valid <= 1'b1;
          end else if (tc) begin
            out  <= {out[0], out[OUT_W-1:1]};
            idx  <= idx - SEL_W'(1);
            wrap <= (idx == '0);
          end
        end
        default: begin
          out       <= '0;
          out_valid <= 1'b0;
          idx       <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_onehot_dec_seq.sv
// Directed bench for onehot_dec_seq with a 2-bit and a 3-bit select instance.
module tb_onehot_dec_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;
  logic [1:0] sel2;
  logic [2:0] sel3;
  logic       sel_valid;
  logic [7:0] dwell;

  logic [3:0] out2;
  logic       out_valid2;
  logic [1:0] idx2;
  logic       wrap2;
  logic [7:0] out3;
  logic       out_valid3;
  logic [2:0] idx3;
  logic       wrap3;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  onehot_dec_seq #(.SEL_W(2), .DWELL_W(8)) u2 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel2),
    .sel_valid(sel_valid), .dwell(dwell), .out(out2), .out_valid(out_valid2),
    .idx(idx2), .wrap(wrap2)
  );

  onehot_dec_seq #(.SEL_W(3), .DWELL_W(8)) u3 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel3),
    .sel_valid(sel_valid), .dwell(dwell), .out(out3), .out_valid(out_valid3),
    .idx(idx3), .wrap(wrap3)
  );

  // {out, out_valid, idx, wrap} bundles for compact comparisons
  wire [7:0]  obs2 = {out2, out_valid2, idx2, wrap2};
  wire [12:0] obs3 = {out3, out_valid3, idx3, wrap3};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; en = 1'b0; mode = 2'b00; sel2 = '0; sel3 = '0;
    sel_valid = 1'b0; dwell = 8'd1;
    tick; tick;
    vectors++;
    if (obs2 !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_hold2 got=%h exp=%h", obs2, 8'h00);
    end
    vectors++;
    if (obs3 !== 13'h0000) begin
      miscompares++;
      $display("FAIL reset_hold3 got=%h exp=%h", obs3, 13'h0000);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      vectors++;
      if (obs2 !== 8'h00) begin
        miscompares++;
        $display("FAIL idle_en0 cyc=%0d got=%h exp=%h", i, obs2, 8'h00);
      end
    end
  endtask

  task automatic test_decode;
    logic [3:0] exp_out [4];
    exp_out[0] = 4'b0001; exp_out[1] = 4'b0010;
    exp_out[2] = 4'b0100; exp_out[3] = 4'b1000;
    en = 1'b1; mode = 2'b00; sel_valid = 1'b0;
    tick;
    vectors++;
    if (obs2 !== 8'h00) begin
      miscompares++;
      $display("FAIL decode_entry got=%h exp=%h", obs2, 8'h00);
    end
    for (int s = 0; s < 4; s++) begin
      sel2 = 2'(s); sel_valid = 1'b1;
      tick;
      vectors++;
      if (obs2 !== {exp_out[s], 1'b1, 2'(s), 1'b0}) begin
        miscompares++;
        $display("FAIL decode_sel%0d got=%h exp=%h", s, obs2,
                 {exp_out[s], 1'b1, 2'(s), 1'b0});
      end
    end
    sel_valid = 1'b0; sel2 = 2'd2;
    for (int i = 0; i < 2; i++) begin
      tick;
      vectors++;
      if (obs2 !== {4'b1000, 1'b1, 2'd3, 1'b0}) begin
        miscompares++;
        $display("FAIL decode_hold cyc=%0d got=%h exp=%h", i, obs2,
                 {4'b1000, 1'b1, 2'd3, 1'b0});
      end
    end
  endtask

  task automatic test_scan_up_wrap;
    logic [7:0] exp_out;
    logic       exp_wrap;
    mode = 2'b01; dwell = 8'd2; sel_valid = 1'b0;
    for (int c = 0; c < 34; c++) begin
      tick;
      exp_out  = 8'd1 << ((c / 2) % 8);
      exp_wrap = (c == 16) || (c == 32);
      vectors++;
      if (obs3 !== {exp_out, 1'b1, 3'((c / 2) % 8), exp_wrap}) begin
        miscompares++;
        $display("FAIL scan_up3 cyc=%0d got=%h exp=%h", c, obs3,
                 {exp_out, 1'b1, 3'((c / 2) % 8), exp_wrap});
      end
    end
  endtask

  task automatic test_scan_dn_dwell0;
    logic [7:0] exp_tab [6];
    exp_tab[0] = {4'b1000, 1'b1, 2'd3, 1'b0};
    exp_tab[1] = {4'b0100, 1'b1, 2'd2, 1'b0};
    exp_tab[2] = {4'b0010, 1'b1, 2'd1, 1'b0};
    exp_tab[3] = {4'b0001, 1'b1, 2'd0, 1'b0};
    exp_tab[4] = {4'b1000, 1'b1, 2'd3, 1'b1};
    exp_tab[5] = {4'b0100, 1'b1, 2'd2, 1'b0};
    mode = 2'b10; dwell = 8'd0;
    for (int c = 0; c < 6; c++) begin
      tick;
      vectors++;
      if (obs2 !== exp_tab[c]) begin
        miscompares++;
        $display("FAIL scan_dn_dwell0 cyc=%0d got=%h exp=%h", c, obs2, exp_tab[c]);
      end
    end
  endtask

  task automatic test_mode_switch;
    mode = 2'b01; dwell = 8'd0;
    tick; tick; tick;
    vectors++;
    if (obs2 !== {4'b0100, 1'b1, 2'd2, 1'b0}) begin
      miscompares++;
      $display("FAIL switch_pre got=%h exp=%h", obs2, {4'b0100, 1'b1, 2'd2, 1'b0});
    end
    mode = 2'b10;
    tick;
    vectors++;
    if (obs2 !== {4'b1000, 1'b1, 2'd3, 1'b0}) begin
      miscompares++;
      $display("FAIL switch_dn got=%h exp=%h", obs2, {4'b1000, 1'b1, 2'd3, 1'b0});
    end
    en = 1'b0;
    tick;
    vectors++;
    if (obs2 !== 8'h00) begin
      miscompares++;
      $display("FAIL disable got=%h exp=%h", obs2, 8'h00);
    end
  endtask

  task automatic test_async_reset;
    logic [7:0] exp_tab [4];
    exp_tab[0] = {4'b0001, 1'b1, 2'd0, 1'b0};
    exp_tab[1] = {4'b0001, 1'b1, 2'd0, 1'b0};
    exp_tab[2] = {4'b0001, 1'b1, 2'd0, 1'b0};
    exp_tab[3] = {4'b0010, 1'b1, 2'd1, 1'b0};
    en = 1'b1; mode = 2'b01; dwell = 8'd1;
    tick; tick; tick;
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (obs2 !== 8'h00) begin
      miscompares++;
      $display("FAIL async_rst_immediate got=%h exp=%h", obs2, 8'h00);
    end
    tick;
    vectors++;
    if (obs2 !== 8'h00) begin
      miscompares++;
      $display("FAIL async_rst_held got=%h exp=%h", obs2, 8'h00);
    end
    dwell = 8'd3;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick;
      vectors++;
      if (obs2 !== exp_tab[c]) begin
        miscompares++;
        $display("FAIL post_rst_dwell3 cyc=%0d got=%h exp=%h", c, obs2, exp_tab[c]);
      end
    end
  endtask

  initial begin
    test_reset;
    test_decode;
    test_scan_up_wrap;
    test_scan_dn_dwell0;
    test_mode_switch;
    test_async_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
